uart_tx_feeder: RTL and testbench

Byte buffer and handshake sequencer that sits directly upstream of the UART transmitter. Producers push bytes into an internal FIFO. The feeder presents one byte at a time on TX_Data and TX_Data_Valid, holding them stable until the transmitter's one-cycle TX_Done_Sig pulse. It then completes the transmitter's release handshake and issues the next byte, giving back-to-back frames with no software pacing.

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo.sv | 96 +++++++++
 rtl/uart_tx_feeder.sv | 119 +++++++++++
 tb/tb_uart_tx_feeder.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: state encoding and data width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter and registered Full/Empty flags.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              wr_reject
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              wr_accept;
  logic              rd_accept;

  // The flags are registered, so a write in the same cycle as a pop at Full is still rejected.
  assign wr_accept = wr_en && !full_q;
  assign rd_accept = rd_en && !empty_q;

  // Next-state for storage, pointers, occupancy counter and flags.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_accept) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == {(ADDR_W+1){1'b0}});
  end

  // State registers with synchronous reset; storage is cleared too so outputs are deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {ADDR_W{1'b0}};
      rd_ptr_q <= {ADDR_W{1'b0}};
      count_q  <= {(ADDR_W+1){1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign wr_reject = wr_en && full_q;

endmodule : sync_fifo

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them one at a time to the UART transmitter,
// completing the transmitter's done/release handshake between frames.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   WR_En,
  input  logic [UART_DATA_W-1:0] WR_Data,
  output logic                   Full,
  output logic                   Empty,
  output logic [ADDR_W:0]        Count,
  output logic                   Overflow,
  input  logic                   TX_Done_Sig,
  output logic                   TX_Data_Valid,
  output logic [UART_DATA_W-1:0] TX_Data,
  output logic                   Busy
);

  state_e                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   overflow_q, overflow_d;
  logic                   pop_s;
  logic [UART_DATA_W-1:0] fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_reject;
  logic [ADDR_W:0]        fifo_count;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (UART_DATA_W)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .wr_en     (WR_En),
    .wr_data   (WR_Data),
    .rd_en     (pop_s),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .wr_reject (fifo_reject)
  );

  // Handshake sequencer: next state, frame data capture, pop request and output flags.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    data_d     = data_q;
    pop_s      = 1'b0;
    overflow_d = fifo_reject;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          data_d  = fifo_rd_data;
          valid_d = 1'b1;
          pop_s   = 1'b1;
          state_d = ST_SEND;
        end else begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        valid_d = 1'b1;
        if (TX_Done_Sig) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_RELEASE: begin
        // Valid stays high during this cycle so the transmitter can return to idle.
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer and output registers; reset aborts any frame in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b0;
      data_q     <= {UART_DATA_W{1'b0}};
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign TX_Data_Valid = valid_q;
  assign TX_Data       = data_q;
  assign Busy          = busy_q;
  assign Overflow      = overflow_q;
  assign Full          = fifo_full;
  assign Empty         = fifo_empty;
  assign Count         = fifo_count;

endmodule : uart_tx_feeder

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder with a simple transmitter model.
module tb_uart_tx_feeder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              WR_En = 1'b0;
  logic [7:0]        WR_Data = 8'h00;
  logic              model_done = 1'b0;
  logic              force_done = 1'b0;
  logic              TX_Done_Sig;
  logic              Full;
  logic              Empty;
  logic [ADDR_W:0]   Count;
  logic              Overflow;
  logic              TX_Data_Valid;
  logic [7:0]        TX_Data;
  logic              Busy;

  assign TX_Done_Sig = model_done | force_done;

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .WR_En         (WR_En),
    .WR_Data       (WR_Data),
    .Full          (Full),
    .Empty         (Empty),
    .Count         (Count),
    .Overflow      (Overflow),
    .TX_Done_Sig   (TX_Done_Sig),
    .TX_Data_Valid (TX_Data_Valid),
    .TX_Data       (TX_Data),
    .Busy          (Busy)
  );

  always #10 CLK = ~CLK;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         cyc = 0;
  int         frames = 0;
  int         ovf_pulses = 0;
  int         max_count = 0;
  int         lat_checks = 0;
  bit         tx_enable = 1'b0;
  int         tx_delay = 100;
  int         done_at = 0;
  bit         frame_active = 1'b0;
  int         done_any = -1;
  int         lat_ref = -1;
  logic       prev_valid = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic [7:0] exp_byte;

  // Output monitor, scoreboard comparison and transmitter model, all on the falling edge.
  always @(negedge CLK) begin
    cyc = cyc + 1;
    model_done = 1'b0;
    if (RST) begin
      prev_valid   = 1'b0;
      frame_active = 1'b0;
      done_any     = -1;
      lat_ref      = -1;
    end else begin
      if (Overflow) ovf_pulses++;
      if (int'(Count) > max_count) max_count = int'(Count);
      if (done_any >= 0 && cyc == done_any + 1) begin
        checks++;
        if (TX_Data_Valid !== 1'b1) begin
          errors++;
          $display("FAIL release_valid cyc=%0d got %b expected 1", cyc, TX_Data_Valid);
        end
      end
      if (done_any >= 0 && cyc == done_any + 2) begin
        checks++;
        if (TX_Data_Valid !== 1'b0) begin
          errors++;
          $display("FAIL gap_valid_low cyc=%0d got %b expected 0", cyc, TX_Data_Valid);
        end
      end
      if (TX_Data_Valid && !prev_valid) begin
        frames++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame got %h expected none", TX_Data);
        end else begin
          exp_byte = sb.pop_front();
          if (TX_Data !== exp_byte) begin
            errors++;
            $display("FAIL frame_data got %h expected %h", TX_Data, exp_byte);
          end
        end
        if (lat_ref >= 0) begin
          checks++;
          lat_checks++;
          if (cyc - lat_ref != 3) begin
            errors++;
            $display("FAIL done_to_valid_latency got %0d expected 3", cyc - lat_ref);
          end
          lat_ref = -1;
        end
        hold_data    = TX_Data;
        done_at      = cyc + tx_delay;
        frame_active = 1'b1;
      end else if (TX_Data_Valid && prev_valid) begin
        checks++;
        if (TX_Data !== hold_data) begin
          errors++;
          $display("FAIL data_stable got %h expected %h", TX_Data, hold_data);
        end
      end
      if (!TX_Data_Valid) frame_active = 1'b0;
      if (tx_enable && frame_active && TX_Data_Valid && cyc >= done_at) begin
        model_done   = 1'b1;
        frame_active = 1'b0;
        done_any     = cyc;
        lat_ref      = (Count != 5'd0) ? cyc : -1;
      end
      prev_valid = TX_Data_Valid;
    end
  end

  // Wait until all expected frames are out and the feeder is idle, within a cycle budget.
  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!(sb.size() == 0 && Busy === 1'b0 && Count === 5'd0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain_timeout got pending=%0d expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({Empty, Full, Busy, TX_Data_Valid, Overflow} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 10000", {Empty, Full, Busy, TX_Data_Valid, Overflow});
    end
    checks++;
    if (Count !== 5'd0 || TX_Data !== 8'h00) begin
      errors++;
      $display("FAIL reset_count_data got %0d/%h expected 0/00", Count, TX_Data);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single();
    int f0;
    f0 = frames;
    tx_enable = 1'b1;
    tx_delay  = 100;
    sb.push_back(8'hA5);
    WR_En = 1'b1;
    WR_Data = 8'hA5;
    @(negedge CLK);
    WR_En = 1'b0;
    checks++;
    if (Empty !== 1'b0 || Count !== 5'd1 || TX_Data_Valid !== 1'b0) begin
      errors++;
      $display("FAIL single_after_write got E=%b C=%0d V=%b expected 0/1/0", Empty, Count, TX_Data_Valid);
    end
    @(negedge CLK);
    checks++;
    if (TX_Data_Valid !== 1'b1 || TX_Data !== 8'hA5 || Busy !== 1'b1 || Count !== 5'd0) begin
      errors++;
      $display("FAIL single_valid_rise got V=%b D=%h B=%b C=%0d expected 1/a5/1/0",
               TX_Data_Valid, TX_Data, Busy, Count);
    end
    wait_idle(300, "single");
    checks++;
    if (frames - f0 != 1) begin
      errors++;
      $display("FAIL single_frames got %0d expected 1", frames - f0);
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    int l0;
    f0 = frames;
    l0 = lat_checks;
    tx_enable = 1'b1;
    tx_delay  = 20;
    for (int i = 1; i <= 3; i++) begin
      sb.push_back(8'(i));
      WR_En = 1'b1;
      WR_Data = 8'(i);
      @(negedge CLK);
    end
    WR_En = 1'b0;
    wait_idle(300, "burst");
    checks++;
    if (frames - f0 != 3 || lat_checks - l0 != 2) begin
      errors++;
      $display("FAIL burst_frames got %0d/%0d expected 3/2", frames - f0, lat_checks - l0);
    end
  endtask

  task automatic test_fill_overflow();
    int f0;
    int o0;
    f0 = frames;
    o0 = ovf_pulses;
    tx_enable = 1'b0;
    tx_delay  = 4;
    for (int i = 0; i < 18; i++) begin
      if (i < 17) sb.push_back(8'h40 + 8'(i));
      WR_En = 1'b1;
      WR_Data = 8'h40 + 8'(i);
      @(negedge CLK);
    end
    WR_En = 1'b0;
    checks++;
    if (Full !== 1'b1 || Count !== 5'd16 || Overflow !== 1'b1) begin
      errors++;
      $display("FAIL fill_full got F=%b C=%0d O=%b expected 1/16/1", Full, Count, Overflow);
    end
    @(negedge CLK);
    checks++;
    if (Overflow !== 1'b0 || Count !== 5'd16) begin
      errors++;
      $display("FAIL overflow_pulse_end got O=%b C=%0d expected 0/16", Overflow, Count);
    end
    tx_enable = 1'b1;
    wait_idle(1000, "fill");
    checks++;
    if (frames - f0 != 17 || ovf_pulses - o0 != 1) begin
      errors++;
      $display("FAIL fill_frames_ovf got %0d/%0d expected 17/1", frames - f0, ovf_pulses - o0);
    end
  endtask

  task automatic test_wrap();
    int f0;
    int n;
    int budget;
    f0 = frames;
    n = 0;
    budget = 0;
    max_count = 0;
    tx_enable = 1'b1;
    tx_delay  = 3;
    while (n < 40 && budget < 1000) begin
      if (Full === 1'b0) begin
        sb.push_back(8'(n));
        WR_En = 1'b1;
        WR_Data = 8'(n);
        n++;
      end else begin
        WR_En = 1'b0;
      end
      @(negedge CLK);
      budget++;
    end
    WR_En = 1'b0;
    checks++;
    if (n != 40) begin
      errors++;
      $display("FAIL wrap_push_timeout got %0d expected 40", n);
    end
    wait_idle(2000, "wrap");
    checks++;
    if (frames - f0 != 40 || max_count > 16) begin
      errors++;
      $display("FAIL wrap_frames_max got %0d/%0d expected 40/<=16", frames - f0, max_count);
    end
  endtask

  task automatic test_reset_midframe();
    int f0;
    tx_enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(8'h90 + 8'(i));
      WR_En = 1'b1;
      WR_Data = 8'h90 + 8'(i);
      @(negedge CLK);
    end
    WR_En = 1'b0;
    @(negedge CLK);
    checks++;
    if (Count !== 5'd5 || TX_Data_Valid !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_setup got C=%0d V=%b B=%b expected 5/1/1", Count, TX_Data_Valid, Busy);
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (TX_Data_Valid !== 1'b0 || Count !== 5'd0 || Empty !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset got V=%b C=%0d E=%b B=%b expected 0/0/1/0",
               TX_Data_Valid, Count, Empty, Busy);
    end
    sb.delete();
    @(negedge CLK);
    RST = 1'b0;
    f0 = frames;
    force_done = 1'b1;
    @(negedge CLK);
    force_done = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (TX_Data_Valid !== 1'b0 || Busy !== 1'b0 || Count !== 5'd0 || Empty !== 1'b1 || frames != f0) begin
      errors++;
      $display("FAIL spurious_done got V=%b B=%b C=%0d E=%b expected 0/0/0/1",
               TX_Data_Valid, Busy, Count, Empty);
    end
    tx_enable = 1'b1;
    tx_delay  = 10;
    sb.push_back(8'h3C);
    WR_En = 1'b1;
    WR_Data = 8'h3C;
    @(negedge CLK);
    WR_En = 1'b0;
    wait_idle(200, "recover");
    checks++;
    if (frames - f0 != 1) begin
      errors++;
      $display("FAIL recover_frames got %0d expected 1", frames - f0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_overflow();
    test_wrap();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_feeder
